ub_input_loader: RTL

//   Read-side initiator for the unified buffer. On start it issues load_input/addr requests,

---
 rtl/ub_input_loader_pkg.sv | 26 ++
 rtl/ub_input_loader_act_skew_reg.sv | 97 +++++++++
 rtl/ub_input_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ub_input_loader_pkg.sv
// ---------------------------------------------------------------------------
// ub_input_loader_pkg
//   Shared constants and the loader FSM state type for the unified-buffer
//   input loader.
//   UB_DATA_W : activation / buffer word width
//   UB_ADDR_W : unified buffer address width
//   UB_CNT_W  : tile counter width
// ---------------------------------------------------------------------------
package ub_input_loader_pkg;

  localparam int UB_DATA_W = 8;
  localparam int UB_ADDR_W = 13;
  localparam int UB_CNT_W  = 8;

  // One request cycle, one capture cycle, three skew cycles per tile.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_CAP  = 3'd2,
    ST_SK0  = 3'd3,
    ST_SK1  = 3'd4,
    ST_SK2  = 3'd5,
    ST_FIN  = 3'd6
  } loader_state_t;

endpackage

// File: rtl/ub_input_loader_act_skew_reg.sv
// ---------------------------------------------------------------------------
// ub_input_loader_act_skew_reg
//   Holds one 2x2 activation tile and presents it skewed to the two array
//   rows. All outputs are registered and computed from the loader's NEXT
//   phase, so the value appears in the same cycle the loader sits in that
//   phase.
// Ports
//   clk, reset           clock, async active-high reset
//   cap_en               loader is in the capture cycle: take ub_in_* now
//   sk0_d/sk1_d/sk2_d    next loader phase is SK0/SK1/SK2
//   ub_in_00..ub_in_11   tile words from the unified buffer
//   act_row1/act_row2    activations into array rows 1 and 2
//   act_valid1/2         row carries data
// ---------------------------------------------------------------------------
module ub_input_loader_act_skew_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_en,
  input  logic              sk0_d,
  input  logic              sk1_d,
  input  logic              sk2_d,
  input  logic [DATA_W-1:0] ub_in_00,
  input  logic [DATA_W-1:0] ub_in_01,
  input  logic [DATA_W-1:0] ub_in_10,
  input  logic [DATA_W-1:0] ub_in_11,
  output logic [DATA_W-1:0] act_row1,
  output logic [DATA_W-1:0] act_row2,
  output logic              act_valid1,
  output logic              act_valid2
);

  logic [DATA_W-1:0] t00_q, t01_q, t10_q, t11_q;
  logic [DATA_W-1:0] t00_d, t01_d, t10_d, t11_d;
  logic [DATA_W-1:0] row1_q, row1_d, row2_q, row2_d;
  logic              v1_q, v1_d, v2_q, v2_d;

  // A stalled loader re-presents the same next phase, so the outputs are
  // recomputed from unchanged tile registers and simply hold.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that left
    // one unassigned would infer a latch.
    t00_d  = cap_en ? ub_in_00 : t00_q;
    t01_d  = cap_en ? ub_in_01 : t01_q;
    t10_d  = cap_en ? ub_in_10 : t10_q;
    t11_d  = cap_en ? ub_in_11 : t11_q;
    row1_d = '0;
    row2_d = '0;
    v1_d   = 1'b0;
    v2_d   = 1'b0;
    if (sk0_d) begin
      row1_d = t00_d;
      v1_d   = 1'b1;
    end
    if (sk1_d) begin
      row1_d = t01_d;
      v1_d   = 1'b1;
      row2_d = t10_d;
      v2_d   = 1'b1;
    end
    if (sk2_d) begin
      row2_d = t11_d;
      v2_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the four tile words are plain flops, not a RAM, so clearing
      // them on reset is cheap and keeps stale activations from escaping.
      t00_q  <= '0;
      t01_q  <= '0;
      t10_q  <= '0;
      t11_q  <= '0;
      row1_q <= '0;
      row2_q <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
    end else begin
      t00_q  <= t00_d;
      t01_q  <= t01_d;
      t10_q  <= t10_d;
      t11_q  <= t11_d;
      row1_q <= row1_d;
      row2_q <= row2_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
    end
  end

  assign act_row1   = row1_q;
  assign act_row2   = row2_q;
  assign act_valid1 = v1_q;
  assign act_valid2 = v2_q;

endmodule

// File: rtl/ub_input_loader.sv
// ---------------------------------------------------------------------------
// ub_input_loader
//   Read-side initiator for the unified buffer. On start it requests
//   tile_count 2x2 activation tiles at base_addr + 4*k, captures each one a
//   cycle after its request and streams it skewed into the two rows of the
//   2x2 systolic array.
// Ports
//   clk, reset              clock, async active-high reset
//   start                   1-cycle pulse, sampled only while idle
//   base_addr, tile_count   job description, sampled with start
//   stall                   array back-pressure, honoured in skew phases
//   ub_load_input, ub_addr  read request / address to the unified buffer
//   ub_in_00..ub_in_11      tile words, valid one cycle after the request
//   act_row1/2, act_valid1/2 skewed activations into the array
//   busy                    high whenever not idle
//   done                    1-cycle pulse after the last tile's last skew
// ---------------------------------------------------------------------------
module ub_input_loader
  import ub_input_loader_pkg::*;
#(
  parameter int DATA_W = UB_DATA_W,
  parameter int ADDR_W = UB_ADDR_W,
  parameter int CNT_W  = UB_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  tile_count,
  input  logic              stall,
  output logic              ub_load_input,
  output logic [ADDR_W-1:0] ub_addr,
  input  logic [DATA_W-1:0] ub_in_00,
  input  logic [DATA_W-1:0] ub_in_01,
  input  logic [DATA_W-1:0] ub_in_10,
  input  logic [DATA_W-1:0] ub_in_11,
  output logic [DATA_W-1:0] act_row1,
  output logic [DATA_W-1:0] act_row2,
  output logic              act_valid1,
  output logic              act_valid2,
  output logic              busy,
  output logic              done
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  k_q, k_d;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    k_d     = k_q;
    addr_d  = addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (tile_count != '0) begin
            base_d  = base_addr;
            count_d = tile_count;
            k_d     = '0;
            state_d = ST_REQ;
          end else begin
            // Empty job: report completion without touching the buffer.
            state_d = ST_FIN;
          end
        end
      end
      ST_REQ:  state_d = ST_CAP;
      ST_CAP:  state_d = ST_SK0;
      ST_SK0:  if (!stall) state_d = ST_SK1;
      ST_SK1:  if (!stall) state_d = ST_SK2;
      ST_SK2: begin
        if (!stall) begin
          k_d     = k_q + CNT_W'(1);
          state_d = (k_d == count_q) ? ST_FIN : ST_REQ;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Address is loaded only on entry to REQ and otherwise holds, so the
    // buffer never sees a glitch back to zero between tiles.
    if (state_d == ST_REQ) begin
      addr_d = base_d + ADDR_W'({k_d, 2'b00});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
      k_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      k_q     <= k_d;
    end
  end

  ub_input_loader_act_skew_reg #(
    .DATA_W (DATA_W)
  ) u_skew (
    .clk        (clk),
    .reset      (reset),
    .cap_en     (state_q == ST_CAP),
    .sk0_d      (state_d == ST_SK0),
    .sk1_d      (state_d == ST_SK1),
    .sk2_d      (state_d == ST_SK2),
    .ub_in_00   (ub_in_00),
    .ub_in_01   (ub_in_01),
    .ub_in_10   (ub_in_10),
    .ub_in_11   (ub_in_11),
    .act_row1   (act_row1),
    .act_row2   (act_row2),
    .act_valid1 (act_valid1),
    .act_valid2 (act_valid2)
  );

  // Decoded straight from the state register, so glitch-free.
  assign ub_load_input = (state_q == ST_REQ);
  assign ub_addr       = addr_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_FIN);

endmodule
